// File: rtl/key_bounce_gen_pkg.sv
// Shared types and width helpers for the key bounce generator.
// Holds the FSM state enum, the LFSR feedback tap mask and width helpers
// used to size the key index, phase counter and bounce counter.
package key_bounce_pkg;

    // Sequencer states: idle, line at target, line glitched, settled.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON     = 2'd1,
        OFF    = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Width of the key index port; never narrower than one bit.
    function automatic int key_idx_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

    // Phase counter width: must hold GAP_MAX itself, hence the extra bit.
    function automatic int gap_cnt_w(input int gap_max);
        return $clog2(gap_max) + 1;
    endfunction

    // Width of the counter that tracks completed ON/OFF pairs.
    function automatic int bounce_cnt_w(input int bounces);
        return (bounces > 1) ? $clog2(bounces) : 1;
    endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clock.
// Reusable pseudo-random source; the seed is loaded on synchronous reset
// and must be non-zero or the register locks up at zero.
module lfsr16
    import key_bounce_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    // Shift left one position per cycle, feeding back the tap parity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/key_bounce_gen.sv
// Push-button emulator: drives active-low key lines with contact bounce.
// A command (key index, press/release) is taken over a valid/ready
// handshake; the selected line then alternates between its target level
// and the inverse for BOUNCES ON/OFF pairs, settles at target for one
// cycle with a done pulse, and holds there until the next command.
// Optional macro KEY_BOUNCE_RANDOM_EN: phase lengths drawn from the LFSR
// (1..GAP_MAX) instead of the fixed GAP_FIX.
module key_bounce_gen
    import key_bounce_pkg::*;
#(
    parameter int          NUM_KEYS  = 5,
    parameter int          BOUNCES   = 4,
    parameter int          GAP_FIX   = 2,
    parameter int          GAP_MAX   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [key_idx_w(NUM_KEYS)-1:0]   cmd_key,
    input  logic                             cmd_press,
    output logic [NUM_KEYS-1:0]              key_n,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int KEY_W  = key_idx_w(NUM_KEYS);
    localparam int CNT_W  = gap_cnt_w(GAP_MAX);
    localparam int BCNT_W = bounce_cnt_w(BOUNCES);
    localparam int RAND_W = CNT_W - 1;

    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_ONE    = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] LAST_BOUNCE = BCNT_W'(BOUNCES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_nxt;
    logic [KEY_W-1:0]  key_sel;
    logic              target;
    logic [15:0]       lfsr_q;
    logic [CNT_W-1:0]  gap_len;
    logic              key_ok;
    logic              take_cmd;
    logic              bad_cmd;
    logic              drive_en;
    logic              drive_lvl;
    logic [KEY_W-1:0]  drive_idx;
    logic              unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // In fixed-gap builds the LFSR output is intentionally left dangling.
    assign unused_lfsr = ^lfsr_q;

`ifdef KEY_BOUNCE_RANDOM_EN
    // Fresh length 1..GAP_MAX sampled at every phase entry.
    assign gap_len = {1'b0, lfsr_q[RAND_W-1:0]} + CNT_ONE;
`else
    assign gap_len = CNT_W'(GAP_FIX);
`endif

    // Zero-extend both sides so a power-of-two NUM_KEYS compares correctly.
    assign key_ok = (32'(cmd_key) < 32'(NUM_KEYS));

    // Next-state, phase counting and line-drive decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bcnt_nxt  = bcnt;
        drive_en  = 1'b0;
        drive_idx = key_sel;
        drive_lvl = target;
        take_cmd  = 1'b0;
        bad_cmd   = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (key_ok) begin
                        take_cmd  = 1'b1;
                        state_nxt = ON;
                        cnt_nxt   = gap_len;
                        bcnt_nxt  = '0;
                        drive_en  = 1'b1;
                        drive_idx = cmd_key;
                        drive_lvl = ~cmd_press;
                    end else begin
                        // Out-of-range index: swallowed, flagged, FSM stays idle.
                        bad_cmd = 1'b1;
                    end
                end
            end
            ON: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = OFF;
                    cnt_nxt   = gap_len;
                    drive_en  = 1'b1;
                    drive_lvl = ~target;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            OFF: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    // Line returns to target whether another pair follows or not.
                    drive_en  = 1'b1;
                    drive_lvl = target;
                    if (bcnt == LAST_BOUNCE) begin
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = ON;
                        cnt_nxt   = gap_len;
                        bcnt_nxt  = bcnt + BCNT_ONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SETTLE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus phase and bounce counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Capture the selected key and its settled level when a command is taken.
    always_ff @(posedge clk) begin
        if (take_cmd) begin
            key_sel <= cmd_key;
            target  <= ~cmd_press;
        end
    end

    // Key line register (only the selected line moves) and error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_n <= '1;
            err   <= 1'b0;
        end else begin
            err <= bad_cmd;
            if (drive_en) begin
                key_n[drive_idx] <= drive_lvl;
            end
        end
    end

endmodule
